mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative multi-cycle multiply/divide unit for the MIPS32 EX stage.
//  Complements the single-cycle ALU by covering MULT/MULTU/DIV/DIVU.
//  Results go to architectural HI/LO registers; MFHI/MFLO read them and MTHI/MTLO write them.
//  Fixed latency lets the hazard unit stall the pipeline on `busy`.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are each WIDTH bits
// PORTS
//  clk           in   1      clock; every register updates on the rising edge
//  rst           in   1      synchronous reset, active-high
//  start         in   1      request; sampled only when busy=0
//  op            in   2      0=MULT 1=MULTU 2=DIV 3=DIVU
//  a             in   WIDTH  multiplicand / dividend (rs)
//  b             in   WIDTH  multiplier / divisor (rt)
//  hi_we         in   1      MTHI write strobe; ignored while busy=1
//  lo_we         in   1      MTLO write strobe; ignored while busy=1
//  wdata         in   WIDTH  MTHI/MTLO data
//  busy          out  1      operation in progress
//  done          out  1      1-cycle pulse when new HI/LO are valid
//  div_by_zero   out  1      sticky per operation: set with done if DIV/DIVU had b=0
//  hi            out  WIDTH  HI register
//  lo            out  WIDTH  LO register
// BEHAVIOUR
//  Reset:
//   - state=IDLE; hi=lo=0; busy=done=div_by_zero=0; iteration counter=0.
//   - rst has priority over all inputs, including mid-operation: the result is discarded.
//  FSM states: IDLE -> RUN -> FIXUP -> IDLE.
//  IDLE:
//   - on start, latch op and |a|,|b| (magnitudes for signed ops; raw for unsigned).
//   - latch the result signs, clear the accumulator, set cnt=0, go to RUN, busy=1.
//  RUN (exactly WIDTH cycles, cnt 0..WIDTH-1):
//   - multiply: shift-add, one multiplier bit per cycle into a 2*WIDTH product.
//   - divide: restoring divide, one quotient bit per cycle.
//   - divide with b=0: still spends WIDTH cycles; the datapath result is discarded.
//  FIXUP (1 cycle):
//   - signed ops: apply sign correction.
//   - write hi/lo on the edge leaving FIXUP; done=1 and busy=0 in the next cycle.
//  Latency: start sampled at edge E0 -> done=1 and new hi/lo visible in the cycle after edge E0+WIDTH+1.
//   - for WIDTH=32: done is high 34 cycles after the start cycle.
//  Results:
//   - MULT/MULTU: {hi,lo} = 2*WIDTH-bit product, two's complement for MULT.
//   - DIV/DIVU: lo=quotient, hi=remainder.
//   - DIV: quotient truncates toward zero; remainder takes the dividend's sign.
//   - DIV with a=0x80000000, b=-1: lo=0x80000000, hi=0, no flag.
//   - b=0: lo=all ones, hi=a (unchanged dividend), div_by_zero=1; flag clears on the next accepted start.
//  Handshake:
//   - start while busy=1 is ignored, no queueing.
//   - start in the cycle done=1 is accepted (busy=0 then).
//   - done is never high while busy=1.
//  MTHI/MTLO:
//   - hi_we/lo_we update hi/lo on the next edge only when busy=0.
//   - if asserted with start, the write lands and is later overwritten by the result.
//   - hi_we and lo_we together write both registers.
//  Operand inputs a/b are don't-care after the start cycle.
// TESTING
//  1 MULTU a=FFFFFFFF b=FFFFFFFF -> hi=FFFFFFFE lo=00000001; done exactly 34 cycles after start; busy high 33 cycles.
//  2 MULT a=-3 b=7 -> hi=FFFFFFFF lo=FFFFFFEB; DIV a=-7 b=2 -> lo=FFFFFFFD hi=FFFFFFFF.
//  3 DIVU a=100 b=0 -> lo=FFFFFFFF hi=00000064 div_by_zero=1; next DIVU 100/7 -> lo=0000000E hi=00000002, flag=0.
//  4 DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=00000000; MULT 80000000*80000000 -> hi=40000000 lo=0.
//  5 second start + hi_we during busy -> ignored, first result intact; start on the done cycle -> accepted, busy next cycle.
//  6 rst asserted 10 cycles into DIV -> hi=lo=0, busy=done=0 next cycle; a fresh MULTU 3*5 -> lo=0000000F after 34 cycles.

Source files
------------

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   Iterative multiply/divide unit for the MIPS32 EX stage. It executes
//   MULT/MULTU/DIV/DIVU one bit per cycle and owns the architectural HI/LO
//   registers, which MTHI/MTLO can also write while the unit is idle.
//   Latency is fixed: start accepted at edge E0, new HI/LO and done visible
//   in the cycle after edge E0+WIDTH+1.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous reset, active-high, highest priority
//   start        operation request, accepted only while busy=0
//   op[1:0]      0=MULT 1=MULTU 2=DIV 3=DIVU
//   a, b         operands (rs, rt); only sampled in the start cycle
//   hi_we,lo_we  MTHI/MTLO strobes, ignored while busy=1
//   wdata        MTHI/MTLO data
//   busy         operation in progress
//   done         one-cycle pulse when new HI/LO are valid
//   div_by_zero  set with done when a divide had b=0, cleared on next start
//   hi, lo       HI/LO registers
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2
    } state_t;

    // Two's complement negate of v when neg is set.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    // Same as cond_neg for the double-width product.
    function automatic logic [PW-1:0] cond_neg_wide(input logic [PW-1:0] v, input logic neg);
        return neg ? (~v + PW'(1)) : v;
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic [CW-1:0]     cnt_r;
    logic              is_div_r;
    logic [WIDTH-1:0]  opa_r;        // |a|: multiplicand, or dividend kept for b=0
    logic [WIDTH-1:0]  opb_r;        // |b|: divisor
    logic [PW-1:0]     prod_r;       // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic              neg_lo_r;     // product sign, or quotient sign
    logic              neg_hi_r;     // remainder sign (dividend sign) for DIV
    logic              bzero_r;
    logic              busy_r;
    logic              done_r;
    logic              dbz_r;
    logic [WIDTH-1:0]  hi_r;
    logic [WIDTH-1:0]  lo_r;

    logic              accept_s;
    logic              signed_s;
    logic [WIDTH-1:0]  a_mag_s;
    logic [WIDTH-1:0]  b_mag_s;
    logic [WIDTH:0]    mul_sum_s;
    logic [PW-1:0]     mul_next_s;
    logic [WIDTH:0]    div_shift_s;
    logic [WIDTH:0]    div_diff_s;
    logic [PW-1:0]     div_next_s;
    logic [PW-1:0]     prod_fix_s;
    logic [WIDTH-1:0]  res_hi_s;
    logic [WIDTH-1:0]  res_lo_s;

    // Operand preparation and one iteration of shift-add / restoring divide.
    always_comb begin
        accept_s    = start && (state_r == ST_IDLE);
        signed_s    = ~op[0];
        a_mag_s     = cond_neg(a, signed_s & a[WIDTH-1]);
        b_mag_s     = cond_neg(b, signed_s & b[WIDTH-1]);
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit (LSB) is set, then shift the whole product right.
        mul_sum_s   = {1'b0, prod_r[PW-1:WIDTH]}
                    + (prod_r[0] ? {1'b0, opa_r} : {(WIDTH+1){1'b0}});
        mul_next_s  = {mul_sum_s, prod_r[WIDTH-1:1]};
        // Divide: shift the next dividend bit into the remainder and try to
        // subtract; a borrow (MSB set) means restore and shift in a 0.
        div_shift_s = {prod_r[PW-1:WIDTH], prod_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opb_r};
        if (div_diff_s[WIDTH]) begin
            div_next_s = {div_shift_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b0};
        end else begin
            div_next_s = {div_diff_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b1};
        end
    end

    // Sign correction applied during FIXUP; b=0 divides bypass the datapath.
    always_comb begin
        prod_fix_s = cond_neg_wide(prod_r, neg_lo_r);
        if (!is_div_r) begin
            res_hi_s = prod_fix_s[PW-1:WIDTH];
            res_lo_s = prod_fix_s[WIDTH-1:0];
        end else if (bzero_r) begin
            res_hi_s = cond_neg(opa_r, neg_hi_r);
            res_lo_s = {WIDTH{1'b1}};
        end else begin
            res_hi_s = cond_neg(prod_r[PW-1:WIDTH], neg_hi_r);
            res_lo_s = cond_neg(prod_r[WIDTH-1:0], neg_lo_r);
        end
    end

    // Next-state logic: IDLE -> RUN (WIDTH cycles) -> FIXUP -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CW'(WIDTH - 1)) begin
                    state_s = ST_FIXUP;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FIXUP: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch, iteration counter and datapath accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= {CW{1'b0}};
            is_div_r <= 1'b0;
            opa_r    <= {WIDTH{1'b0}};
            opb_r    <= {WIDTH{1'b0}};
            prod_r   <= {PW{1'b0}};
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
            bzero_r  <= 1'b0;
        end else if (accept_s) begin
            cnt_r    <= {CW{1'b0}};
            is_div_r <= op[1];
            opa_r    <= a_mag_s;
            opb_r    <= b_mag_s;
            prod_r   <= {{WIDTH{1'b0}}, (op[1] ? a_mag_s : b_mag_s)};
            neg_lo_r <= signed_s & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi_r <= signed_s & op[1] & a[WIDTH-1];
            bzero_r  <= (b == {WIDTH{1'b0}});
        end else if (state_r == ST_RUN) begin
            cnt_r    <= cnt_r + CW'(1);
            prod_r   <= is_div_r ? div_next_s : mul_next_s;
        end
    end

    // Architectural HI/LO plus registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            done_r <= (state_r == ST_FIXUP);
            if (state_r == ST_FIXUP) begin
                hi_r  <= res_hi_s;
                lo_r  <= res_lo_s;
                dbz_r <= is_div_r & bzero_r;
            end else begin
                if (!busy_r && hi_we) begin
                    hi_r <= wdata;
                end
                if (!busy_r && lo_we) begin
                    lo_r <= wdata;
                end
                if (accept_s) begin
                    dbz_r <= 1'b0;
                end
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a vector table of complete operations
// followed by hand-written sequences for handshake, MTHI/MTLO and reset.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns in cycle 1 after the start cycle.
    task automatic issue_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        cyc();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Wait (bounded) for done. 'first' is the current cycle index relative to
    // the start cycle; lat returns the cycle in which done was seen.
    task automatic wait_done(input int first, output int lat, output int bcnt);
        lat  = first;
        bcnt = 0;
        while (!done && lat < 60) begin
            if (busy) bcnt++;
            cyc();
            lat++;
        end
        if (done && busy) begin
            errors++;
            $display("FAIL done_with_busy actual=1 required=0");
        end
    endtask

    int lat;
    int bcnt;

    initial begin
        vecs[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{2'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
        vecs[4]  = '{2'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
        vecs[5]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[7]  = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{2'd2, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1};
        vecs[9]  = '{2'd1, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 1'b0};
        vecs[10] = '{2'd0, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, 1'b0};
        vecs[11] = '{2'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};

        rst = 1'b1; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
        cyc();
        cyc();
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b0;
        cyc();

        // Table of complete operations.
        for (int i = 0; i < 12; i++) begin
            issue_start(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_busy1", i), {31'd0, busy}, 32'd1);
            check($sformatf("vec%0d_dbzclr", i), {31'd0, div_by_zero}, 32'd0);
            wait_done(1, lat, bcnt);
            check($sformatf("vec%0d_lat", i), lat, 32'd34);
            check($sformatf("vec%0d_busycyc", i), bcnt, 32'd33);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
            check($sformatf("vec%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
            cyc();
            check($sformatf("vec%0d_donepulse", i), {31'd0, done}, 32'd0);
        end

        // Reset 10 cycles into a DIV: result discarded, registers cleared.
        issue_start(2'd2, 32'hFFFFFFF9, 32'h00000002);
        for (int i = 0; i < 9; i++) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        issue_start(2'd1, 32'd3, 32'd5);
        wait_done(1, lat, bcnt);
        check("postrst_lat", lat, 32'd34);
        check("postrst_lo", lo, 32'h0000000F);
        check("postrst_hi", hi, 32'h0);
        cyc();

        // Start and MTHI while busy are ignored.
        issue_start(2'd1, 32'd6, 32'd7);
        for (int i = 0; i < 4; i++) cyc();
        start = 1'b1; op = 2'd3; a = 32'd99; b = 32'd0;
        hi_we = 1'b1; wdata = 32'hDEADBEEF;
        cyc();
        start = 1'b0; hi_we = 1'b0;
        check("ign_hi_mid", hi, 32'h0);
        wait_done(6, lat, bcnt);
        check("ign_lat", lat, 32'd34);
        check("ign_lo", lo, 32'd42);
        check("ign_hi", hi, 32'h0);
        check("ign_dbz", {31'd0, div_by_zero}, 32'd0);

        // Start in the done cycle is accepted.
        issue_start(2'd0, 32'hFFFFFFFE, 32'd3);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_done", {31'd0, done}, 32'd0);
        wait_done(1, lat, bcnt);
        check("b2b_lat", lat, 32'd34);
        check("b2b_hi", hi, 32'hFFFFFFFF);
        check("b2b_lo", lo, 32'hFFFFFFFA);
        cyc();

        // MTHI+MTLO together while idle.
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5A5A5;
        cyc();
        hi_we = 1'b0; lo_we = 1'b0;
        check("mt_hi", hi, 32'hA5A5A5A5);
        check("mt_lo", lo, 32'hA5A5A5A5);

        // MTLO together with start: lands, later overwritten by the result.
        lo_we = 1'b1; wdata = 32'h12345678;
        issue_start(2'd1, 32'd3, 32'd5);
        lo_we = 1'b0;
        check("mtstart_lo", lo, 32'h12345678);
        check("mtstart_hi", hi, 32'hA5A5A5A5);
        wait_done(1, lat, bcnt);
        check("mtstart_res_lo", lo, 32'h0000000F);
        check("mtstart_res_hi", hi, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
